// File: rtl/data_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : data_mem_responder
// Description : Multi-cycle data memory behind a valid/ready load/store port.
//               It adds programmable wait states, merges store byte lanes and
//               extracts and extends load data.
//               Optional macro DMEM_MISALIGN_TRAP_EN faults misaligned
//               half/word accesses. When it is undefined, those addresses
//               are forced to alignment instead.
// Revision    : 1.0 - initial release
// ============================================================================
module data_mem_responder #(
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int         c_addr_lsb  = 2;
    localparam int         c_idx_w     = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [3:0] c_wait_load = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_WAIT   = 2'd1,
        S_ACCESS = 2'd2,
        S_RESP   = 2'd3
    } state_t;

    state_t      r_state;
    logic [3:0]  r_cnt;
    logic        r_we;
    logic [1:0]  r_size;
    logic        r_uns;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic        r_req_ready;
    logic        r_rsp_valid;
    logic [31:0] r_rsp_rdata;
    logic        r_rsp_err;

    logic [31:0] r_mem [DEPTH_WORDS];

    logic [c_idx_w-1:0] w_idx;
    logic [1:0]         w_off;
    logic               w_range_err;
    logic               w_size_err;
    logic               w_align_err;
    logic               w_fault;
    logic [3:0]         w_be;
    logic [31:0]        w_wd;
    logic [31:0]        w_rword;
    logic [31:0]        w_shift;
    logic [31:0]        w_rdata;

    assign w_idx       = r_addr[c_addr_lsb +: c_idx_w];
    // Range check uses the whole word address so aliases above the array fault.
    assign w_range_err = ({2'b00, r_addr[31:c_addr_lsb]} >= 32'(DEPTH_WORDS));
    assign w_size_err  = (r_size == 2'd3);
    assign w_fault     = w_size_err | w_range_err | w_align_err;

`ifdef DMEM_MISALIGN_TRAP_EN
    assign w_align_err = ((r_size == 2'd1) && r_addr[0]) ||
                         ((r_size == 2'd2) && (r_addr[1:0] != 2'b00));
    assign w_off       = r_addr[1:0];
`else
    assign w_align_err = 1'b0;
    always_comb begin
        w_off = r_addr[1:0];
        case (r_size)
            2'd1:    w_off = {r_addr[1], 1'b0};
            2'd2:    w_off = 2'b00;
            default: w_off = r_addr[1:0];
        endcase
    end
`endif

    always_comb begin
        w_be = 4'b0000;
        w_wd = r_wdata;
        case (r_size)
            2'd0: begin
                w_be = 4'b0001 << w_off;
                w_wd = {4{r_wdata[7:0]}};
            end
            2'd1: begin
                w_be = 4'b0011 << w_off;
                w_wd = {2{r_wdata[15:0]}};
            end
            2'd2:    w_be = 4'b1111;
            default: w_be = 4'b0000;
        endcase
    end

    assign w_rword = r_mem[w_idx];
    assign w_shift = w_rword >> {w_off, 3'b000};

    always_comb begin
        w_rdata = 32'd0;
        if (!r_we && !w_fault) begin
            case (r_size)
                2'd0:    w_rdata = r_uns ? {24'd0, w_shift[7:0]}
                                         : {{24{w_shift[7]}}, w_shift[7:0]};
                2'd1:    w_rdata = r_uns ? {16'd0, w_shift[15:0]}
                                         : {{16{w_shift[15]}}, w_shift[15:0]};
                default: w_rdata = w_rword;
            endcase
        end
    end

    // Storage is intentionally not reset.
    always_ff @(posedge clk) begin
        if (!rst && (r_state == S_ACCESS) && r_we && !w_fault) begin
            for (int i = 0; i < 4; i++) begin
                if (w_be[i]) begin
                    r_mem[w_idx][8*i +: 8] <= w_wd[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= 4'd0;
            r_we        <= 1'b0;
            r_size      <= 2'd0;
            r_uns       <= 1'b0;
            r_addr      <= 32'd0;
            r_wdata     <= 32'd0;
            r_req_ready <= 1'b1;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= 32'd0;
            r_rsp_err   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req_valid && r_req_ready) begin
                        r_we        <= req_we;
                        r_size      <= req_size;
                        r_uns       <= req_unsigned;
                        r_addr      <= req_addr;
                        r_wdata     <= req_wdata;
                        r_req_ready <= 1'b0;
                        if (WAIT_CYCLES > 0) begin
                            r_cnt   <= c_wait_load;
                            r_state <= S_WAIT;
                        end else begin
                            r_state <= S_ACCESS;
                        end
                    end
                end
                S_WAIT: begin
                    if (r_cnt == 4'd0) begin
                        r_state <= S_ACCESS;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                S_ACCESS: begin
                    r_rsp_rdata <= w_rdata;
                    r_rsp_err   <= w_fault;
                    r_rsp_valid <= 1'b1;
                    r_state     <= S_RESP;
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_req_ready <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_req_ready <= 1'b1;
                    r_rsp_valid <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready = r_req_ready;
    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rsp_rdata;
    assign rsp_err   = r_rsp_err;

endmodule
`default_nettype wire
